// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the load-use hazard / stall controller.
//   hz_state_t   : controller state (RUN, LOAD_WAIT)
//   OP_*         : MIPS I-type opcodes whose rt field is a destination
//   rt_is_dest() : 1 when the opcode writes rt rather than reading it
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } hz_state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // An rt that is only written by the ID instruction cannot be a load-use
    // dependency, so a match on it must not stall.
    function automatic logic rt_is_dest(input logic [5:0] op);
        logic res;
        case (op)
            OP_LW, OP_XORI, OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_SLTI, OP_SLTIU, OP_LUI: res = 1'b1;
            default:                           res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_match_cmp.sv
// -----------------------------------------------------------------------------
// reg_match_cmp
// Register-index equality compare with optional $zero exemption.
//   a     in  AW  load destination register (EX rt)
//   b     in  AW  source register being checked (ID rs or rt)
//   match out 1   a==b, suppressed for a==0 when ZERO_EXEMPT is set
// -----------------------------------------------------------------------------
module reg_match_cmp #(
    parameter int AW          = 5,
    parameter int ZERO_EXEMPT = 1
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic          match
);

    // Writes to $zero are discarded, so they never create a real dependency.
    assign match = (a == b) && !((ZERO_EXEMPT != 0) && (a == '0));

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Load-use hazard detector and pipeline stall/freeze controller (ID/EX).
//   clk, rst_n        clock, async active-low reset
//   ex_mem_read,ex_rt load in EX and its destination register
//   id_valid,id_rs,
//   id_rt,id_op       instruction currently in ID
//   mem_req,mem_ready MEM-stage data access handshake
//   flush_req         squash the ID instruction
//   stall_cnt_clr     synchronous clear of stall_cycles
//   pc_we,ifid_we     front-end write enables
//   idex_bubble       insert NOP into ID/EX
//   pipe_freeze       hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles      saturating count of cycles with pc_we==0
//   mem_timeout_err   sticky flag: memory frozen longer than MEM_TIMEOUT
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int OP_W        = 6,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_EXEMPT = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [OP_W-1:0]   id_op,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              flush_req,
    input  logic              stall_cnt_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              mem_timeout_err
);

    localparam int               FRZ_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [3:0]       LAT_INIT  = 4'(LOAD_LAT - 1);
    localparam logic [FRZ_W-1:0] FRZ_LIMIT = FRZ_W'(MEM_TIMEOUT);

    hz_state_t          state_q, state_d;
    logic [3:0]         lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [FRZ_W-1:0]   frz_cnt_q, frz_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic               rs_match;
    logic               rt_match;
    logic               hazard;
    logic               freeze;
    logic [5:0]         op6;

    reg_match_cmp #(.AW(REG_AW), .ZERO_EXEMPT(ZERO_EXEMPT)) u_rs_cmp (
        .a     (ex_rt),
        .b     (id_rs),
        .match (rs_match)
    );

    reg_match_cmp #(.AW(REG_AW), .ZERO_EXEMPT(ZERO_EXEMPT)) u_rt_cmp (
        .a     (ex_rt),
        .b     (id_rt),
        .match (rt_match)
    );

    assign op6    = 6'(id_op);
    assign hazard = ex_mem_read && id_valid && (rs_match || (rt_match && !rt_is_dest(op6)));
    assign freeze = mem_req && !mem_ready;

    // Stall outputs are combinational so the bubble goes in the same cycle
    // the hazard is seen. Reset forces the idle pattern regardless of inputs.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
            end else if (!flush_req && ((state_q == LOAD_WAIT) || hazard)) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // The first stall cycle happens in RUN, so LOAD_WAIT covers the remaining
    // LOAD_LAT-1 cycles. A freeze holds the FSM wherever it is.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        if (!freeze) begin
            case (state_q)
                RUN: begin
                    if (!flush_req && hazard && (LOAD_LAT > 1)) begin
                        state_d   = LOAD_WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
                LOAD_WAIT: begin
                    if (flush_req || (lat_cnt_q <= 4'd1)) begin
                        state_d   = RUN;
                        lat_cnt_d = '0;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d   = RUN;
                    lat_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_cnt_clr) begin
            stall_cycles_d = '0;
        end else if (!pc_we && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // frz_cnt saturates at the limit; the flag latches on the first frozen
    // edge that sees the limit already reached.
    always_comb begin
        frz_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
        if (freeze) begin
            frz_cnt_d = (frz_cnt_q == FRZ_LIMIT) ? frz_cnt_q : frz_cnt_q + 1'b1;
            if (frz_cnt_q == FRZ_LIMIT) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            lat_cnt_q      <= '0;
            stall_cycles_q <= '0;
            frz_cnt_q      <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            frz_cnt_q      <= frz_cnt_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign mem_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: one instance with single-cycle load
// stall (u1) and one with a 3-cycle load stall (u3), sharing all inputs.
module tb_hazard_stall_unit;

   logic       clk = 1'b0;
   logic       rstN;
   logic       exMemRead;
   logic [4:0] exRt;
   logic       idValid;
   logic [4:0] idRs;
   logic [4:0] idRt;
   logic [5:0] idOp;
   logic       memReq;
   logic       memReady;
   logic       flushReq;
   logic       cntClr;

   logic        pcWe1, ifidWe1, bubble1, freeze1, err1;
   logic [31:0] stall1;
   logic        pcWe3, ifidWe3, bubble3, freeze3, err3;
   logic [31:0] stall3;

   int checkCount = 0;
   int errorCount = 0;

   hazard_stall_unit #(.LOAD_LAT(1), .MEM_TIMEOUT(8)) u1 (
      .clk(clk), .rst_n(rstN), .ex_mem_read(exMemRead), .ex_rt(exRt),
      .id_valid(idValid), .id_rs(idRs), .id_rt(idRt), .id_op(idOp),
      .mem_req(memReq), .mem_ready(memReady), .flush_req(flushReq),
      .stall_cnt_clr(cntClr), .pc_we(pcWe1), .ifid_we(ifidWe1),
      .idex_bubble(bubble1), .pipe_freeze(freeze1), .stall_cycles(stall1),
      .mem_timeout_err(err1));

   hazard_stall_unit #(.LOAD_LAT(3), .MEM_TIMEOUT(8)) u3 (
      .clk(clk), .rst_n(rstN), .ex_mem_read(exMemRead), .ex_rt(exRt),
      .id_valid(idValid), .id_rs(idRs), .id_rt(idRt), .id_op(idOp),
      .mem_req(memReq), .mem_ready(memReady), .flush_req(flushReq),
      .stall_cnt_clr(cntClr), .pc_we(pcWe3), .ifid_we(ifidWe3),
      .idex_bubble(bubble3), .pipe_freeze(freeze3), .stall_cycles(stall3),
      .mem_timeout_err(err3));

   // 10 ns clock, active edge at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Compares one observed value against its expected value and tallies it.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Drives one full set of ID/EX/MEM inputs.
   task automatic applyStimulus(input logic rd, input logic [4:0] rt, input logic vld,
                                input logic [4:0] rs, input logic [4:0] irt, input logic [5:0] op,
                                input logic req, input logic rdy, input logic fl);
      exMemRead = rd;  exRt = rt;  idValid = vld;
      idRs = rs;  idRt = irt;  idOp = op;
      memReq = req;  memReady = rdy;  flushReq = fl;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic loadUse();
      applyStimulus(1'b1, 5'd8, 1'b1, 5'd8, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0);
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let both instances return to RUN, then zero their stall counters.
   task automatic settle();
      idle();
      cntClr = 1'b0;
      repeat (4) tick();
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
   endtask

   initial begin
      // Reset forces idle outputs even with a live hazard on the inputs.
      rstN   = 1'b0;
      cntClr = 1'b0;
      loadUse();
      #2;
      checkOutput("rst_pc_we", {31'd0, pcWe3}, 32'd1);
      checkOutput("rst_ifid_we", {31'd0, ifidWe1}, 32'd1);
      checkOutput("rst_bubble", {31'd0, bubble3}, 32'd0);
      checkOutput("rst_freeze", {31'd0, freeze1}, 32'd0);
      checkOutput("rst_stall_cycles", stall3, 32'd0);
      checkOutput("rst_err", {31'd0, err3}, 32'd0);
      #10;
      rstN = 1'b1;
      settle();

      // Single-cycle load-use stall on u1.
      loadUse();
      #1;
      checkOutput("ll1_pc_we", {31'd0, pcWe1}, 32'd0);
      checkOutput("ll1_ifid_we", {31'd0, ifidWe1}, 32'd0);
      checkOutput("ll1_bubble", {31'd0, bubble1}, 32'd1);
      tick();
      idle();
      #1;
      checkOutput("ll1_after_pc_we", {31'd0, pcWe1}, 32'd1);
      checkOutput("ll1_after_bubble", {31'd0, bubble1}, 32'd0);
      checkOutput("ll1_stall_cycles", stall1, 32'd1);
      settle();

      // Clear wins over an increment in the same cycle.
      loadUse();
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      idle();
      #1;
      checkOutput("clr_priority", stall1, 32'd0);
      settle();

      // rt matching: only a non-destination rt creates a hazard; $zero exempt.
      applyStimulus(1'b1, 5'd8, 1'b1, 5'd3, 5'd8, 6'b001110, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("rt_xori_no_stall", {31'd0, pcWe1}, 32'd1);
      applyStimulus(1'b1, 5'd8, 1'b1, 5'd3, 5'd8, 6'b100011, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("rt_lw_no_stall", {31'd0, pcWe3}, 32'd1);
      applyStimulus(1'b1, 5'd8, 1'b1, 5'd3, 5'd8, 6'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("rt_rtype_stall", {31'd0, bubble1}, 32'd1);
      applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 5'd3, 6'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("zero_exempt", {31'd0, pcWe1}, 32'd1);
      applyStimulus(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("id_invalid", {31'd0, bubble3}, 32'd0);
      applyStimulus(1'b1, 5'd8, 1'b1, 5'd8, 5'd0, 6'd0, 1'b0, 1'b1, 1'b1);
      #1;
      checkOutput("flush_no_stall", {31'd0, pcWe3}, 32'd1);
      idle();
      settle();

      // Three-cycle load-use stall on u3.
      loadUse();
      #1;
      checkOutput("ll3_c1_bubble", {31'd0, bubble3}, 32'd1);
      tick();
      idle();
      #1;
      checkOutput("ll3_c2_bubble", {31'd0, bubble3}, 32'd1);
      tick();
      checkOutput("ll3_c3_pc_we", {31'd0, pcWe3}, 32'd0);
      tick();
      checkOutput("ll3_done_pc_we", {31'd0, pcWe3}, 32'd1);
      checkOutput("ll3_stall_cycles", stall3, 32'd3);
      settle();

      // Freeze for 4 cycles starting in the second stall cycle.
      loadUse();
      #1;
      checkOutput("frz_c1_bubble", {31'd0, bubble3}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("frz_f%0d_freeze", i), {31'd0, freeze3}, 32'd1);
         checkOutput($sformatf("frz_f%0d_bubble", i), {31'd0, bubble3}, 32'd0);
         checkOutput($sformatf("frz_f%0d_pc_we", i), {31'd0, pcWe3}, 32'd0);
         tick();
      end
      idle();
      #1;
      checkOutput("frz_resume1_bubble", {31'd0, bubble3}, 32'd1);
      tick();
      checkOutput("frz_resume2_bubble", {31'd0, bubble3}, 32'd1);
      tick();
      checkOutput("frz_done_pc_we", {31'd0, pcWe3}, 32'd1);
      checkOutput("frz_stall_cycles3", stall3, 32'd7);
      checkOutput("frz_stall_cycles1", stall1, 32'd5);
      settle();

      // Memory timeout: 8 frozen cycles tolerated, the 9th sets the flag.
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
      repeat (8) tick();
      memReady = 1'b1;
      #1;
      checkOutput("to8_err1", {31'd0, err1}, 32'd0);
      tick();
      checkOutput("to8_err3_after", {31'd0, err3}, 32'd0);
      memReady = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         checkOutput($sformatf("to9_c%0d_err", i), {31'd0, err1}, 32'd0);
         tick();
      end
      memReady = 1'b1;
      #1;
      checkOutput("to9_c10_err1", {31'd0, err1}, 32'd1);
      checkOutput("to9_c10_err3", {31'd0, err3}, 32'd1);
      checkOutput("to_stall_cycles1", stall1, 32'd17);
      tick();
      idle();
      tick();
      checkOutput("to_sticky", {31'd0, err1}, 32'd1);
      settle();

      // Asynchronous reset in the middle of a LOAD_WAIT stall.
      loadUse();
      tick();
      idle();
      #1;
      checkOutput("rstmid_pre_pc_we", {31'd0, pcWe3}, 32'd0);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("rstmid_pc_we", {31'd0, pcWe3}, 32'd1);
      checkOutput("rstmid_bubble", {31'd0, bubble3}, 32'd0);
      checkOutput("rstmid_stall_cycles", stall3, 32'd0);
      checkOutput("rstmid_err", {31'd0, err1}, 32'd0);
      tick();
      #2;
      rstN = 1'b1;
      tick();
      loadUse();
      #1;
      checkOutput("rstpost_c1", {31'd0, bubble3}, 32'd1);
      tick();
      idle();
      #1;
      checkOutput("rstpost_c2", {31'd0, bubble3}, 32'd1);
      tick();
      checkOutput("rstpost_c3", {31'd0, bubble3}, 32'd1);
      tick();
      checkOutput("rstpost_done", {31'd0, pcWe3}, 32'd1);
      checkOutput("rstpost_stall_cycles", stall3, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
